// File: rtl/prio_grant_arb.sv
// Registered N-input priority arbiter with a valid/ready grant handshake.
// Define PRIO_GRANT_ARB_RR_EN to build the run-time selectable round-robin mode.
module prio_grant_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] win;
  logic [W-1:0] fp_win;

  // Fixed priority: highest set index wins, so later iterations overwrite.
  always_comb begin
    fp_win = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[W'(i)]) fp_win = W'(i);
    end
  end

`ifdef PRIO_GRANT_ARB_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] rr_win;
  logic [W-1:0] pos;

  // At a transfer the pointer takes out_idx on this same edge, so search from it.
  always_comb begin
    base   = (state == GRANT) ? out_idx : ptr;
    rr_win = '0;
    pos    = '0;
    // Walk lowest to highest priority; the last hit is the first in descending order from base-1.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = W'((int'(base) + int'(N) - 1 - k) % int'(N));
      if (req[pos]) rr_win = pos;
    end
  end

  assign win = mode ? rr_win : fp_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == GRANT && out_ready) begin
      ptr <= out_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign win         = fp_win;
`endif

  // Grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            out_valid  <= 1'b1;
            out_idx    <= win;
            out_onehot <= N'(1) << win;
          end
        end
        GRANT: begin
          if (out_ready) begin
            if (|req) begin
              out_idx    <= win;
              out_onehot <= N'(1) << win;
            end else begin
              state      <= IDLE;
              out_valid  <= 1'b0;
              out_onehot <= '0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          out_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_grant_arb.sv
// Directed self-checking bench for prio_grant_arb at N=8; covers the
// round-robin build when PRIO_GRANT_ARB_RR_EN is defined.
module tb_prio_grant_arb;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  int n_checks = 0;
  int n_fail   = 0;

  prio_grant_arb #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_onehot(out_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int idx);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".idx"}, 64'(out_idx), 64'(idx));
    check({tag, ".onehot"}, 64'(out_onehot), 64'(8'd1 << idx));
  endtask

  task automatic check_idle(input string tag, input int idx);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".idx"}, 64'(out_idx), 64'(idx));
    check({tag, ".onehot"}, 64'(out_onehot), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    mode      = 1'b0;
    out_ready = 1'b0;
    #1;

    // Reset held two cycles with all requests asserted.
    step();
    step();
    check_idle("reset", 0);

    rst = 1'b0;
    step();
    check_grant("first_grant", 7);

    // Fixed priority, back-to-back transfers.
    req       = 8'b0001_0110;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant("fixed", 4);
    end

    // Stall: request and mode changes are ignored while out_ready is low.
    req = 8'h06;
    step();
    check_grant("stall_start", 2);
    out_ready = 1'b0;
    req = 8'h00;
    step();
    check_grant("stall1", 2);
    req = 8'h80;
    step();
    check_grant("stall2", 2);
    req  = 8'h06;
    mode = 1'b1;
    step();
    check_grant("stall3", 2);
    mode      = 1'b0;
    req       = 8'h80;
    out_ready = 1'b1;
    step();
    check_grant("after_stall", 7);
    req = 8'h00;
    step();
    check_idle("drain", 7);

    // Reset asserted during a held grant.
    out_ready = 1'b0;
    req       = 8'h08;
    step();
    check_grant("pre_reset", 3);
    rst = 1'b1;
    step();
    check_idle("mid_reset", 0);
    rst = 1'b0;
    req = 8'h00;
    step();
    check_idle("post_reset", 0);

`ifdef PRIO_GRANT_ARB_RR_EN
    // Round-robin, all requesting: 7 down to 0 then wrap to 7.
    mode      = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check_grant($sformatf("rr_full%0d", i), (15 - i) % 8);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check_grant($sformatf("rr_sparse%0d", i), (i % 2 == 0) ? 7 : 0);
    end

    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant($sformatf("rr_to_fixed%0d", i), 7);
    end
`else
    // Mode has no effect without the round-robin build.
    mode      = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant($sformatf("mode_ignored%0d", i), 7);
    end
`endif

    req = 8'h00;
    step();
    check_idle("final_idle", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
